// File: rtl/dec_neuron_mac.sv
// Fixed-point neuron MAC: accumulates N_IN weighted activation beats, adds bias, rounds, saturates.
// Optional macro DEC_NEURON_RELU_EN clamps negative results to zero.
module dec_neuron_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int N_IN       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] w0,
  input  logic signed [DATA_WIDTH-1:0] w1,
  input  logic signed [DATA_WIDTH-1:0] w2,
  input  logic signed [DATA_WIDTH-1:0] w3,
  input  logic signed [DATA_WIDTH-1:0] w4,
  input  logic signed [DATA_WIDTH-1:0] w5,
  input  logic signed [DATA_WIDTH-1:0] w6,
  input  logic signed [DATA_WIDTH-1:0] w7,
  input  logic signed [DATA_WIDTH-1:0] w8,
  input  logic signed [DATA_WIDTH-1:0] w9,
  input  logic signed [DATA_WIDTH-1:0] w10,
  input  logic signed [DATA_WIDTH-1:0] w11,
  input  logic signed [DATA_WIDTH-1:0] w12,
  input  logic signed [DATA_WIDTH-1:0] w13,
  input  logic signed [DATA_WIDTH-1:0] w14,
  input  logic signed [DATA_WIDTH-1:0] w15,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  localparam int ACC_W  = 2 * DATA_WIDTH + 5;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ROUND_HALF =
    {{(ACC_W - 1){1'b0}}, 1'b1} <<< (FRAC_BITS - 1);

  typedef enum logic [1:0] {ACC, FIN, OUT} state_t;

  state_t                         state;
  state_t                         state_next;
  logic        [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0]        acc;
  logic signed [DATA_WIDTH-1:0]   w_arr [16];
  logic signed [DATA_WIDTH-1:0]   weight_sel;
  logic signed [PROD_W-1:0]       product;
  logic signed [ACC_W-1:0]        product_ext;
  logic signed [ACC_W-1:0]        bias_ext;
  logic signed [ACC_W-1:0]        round_sum;
  logic signed [ACC_W-1:0]        scaled;
  logic signed [DATA_WIDTH-1:0]   sat_result;
  logic signed [DATA_WIDTH-1:0]   fin_result;
  logic                           accept;
  logic                           last_beat;

  assign w_arr[0]  = w0;
  assign w_arr[1]  = w1;
  assign w_arr[2]  = w2;
  assign w_arr[3]  = w3;
  assign w_arr[4]  = w4;
  assign w_arr[5]  = w5;
  assign w_arr[6]  = w6;
  assign w_arr[7]  = w7;
  assign w_arr[8]  = w8;
  assign w_arr[9]  = w9;
  assign w_arr[10] = w10;
  assign w_arr[11] = w11;
  assign w_arr[12] = w12;
  assign w_arr[13] = w13;
  assign w_arr[14] = w14;
  assign w_arr[15] = w15;

  // Weights are used live, selected by the current beat index.
  always_comb begin
    weight_sel = '0;
    for (int i = 0; i < 16; i++) begin
      if (cnt == CNT_W'(i)) weight_sel = w_arr[i];
    end
  end

  assign product     = in_data * weight_sel;
  assign product_ext = {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};
  assign accept      = in_valid && (state == ACC);
  assign last_beat   = (cnt == CNT_W'(N_IN - 1));

  assign bias_ext  = {{(ACC_W - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
  assign round_sum = acc + (bias_ext <<< FRAC_BITS) + ROUND_HALF;
  assign scaled    = round_sum >>> FRAC_BITS;

  always_comb begin
    if (scaled > SAT_MAX)
      sat_result = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    else if (scaled < SAT_MIN)
      sat_result = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    else
      sat_result = scaled[DATA_WIDTH-1:0];
  end

`ifdef DEC_NEURON_RELU_EN
  assign fin_result = sat_result[DATA_WIDTH-1] ? '0 : sat_result;
`else
  assign fin_result = sat_result;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      ACC: begin
        in_ready = 1'b1;
        if (accept && last_beat) state_next = FIN;
      end
      FIN: state_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACC;
      end
      default: state_next = ACC;
    endcase
  end

  // FIN registers the result and clears the accumulator for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        acc <= acc + product_ext;
        cnt <= last_beat ? '0 : cnt + 1'b1;
      end
      if (state == FIN) begin
        out_data <= fin_result;
        acc      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dec_neuron_mac.sv
// Scoreboard testbench for dec_neuron_mac: model results queued per frame, compared on output.
module tb_dec_neuron_mac;

  localparam int N = 16;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] w_tb [N];
  logic signed [15:0] x_tb [N];
  logic signed [15:0] bias;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;

  int          assert_cnt = 0;
  int          fail_cnt   = 0;
  logic [15:0] exp_q [$];

  dec_neuron_mac dut (
    .clk(clk), .rst_n(rst_n),
    .w0(w_tb[0]), .w1(w_tb[1]), .w2(w_tb[2]), .w3(w_tb[3]),
    .w4(w_tb[4]), .w5(w_tb[5]), .w6(w_tb[6]), .w7(w_tb[7]),
    .w8(w_tb[8]), .w9(w_tb[9]), .w10(w_tb[10]), .w11(w_tb[11]),
    .w12(w_tb[12]), .w13(w_tb[13]), .w14(w_tb[14]), .w15(w_tb[15]),
    .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: Q8.8 MAC with bias, round-half-up, saturate, optional ReLU.
  function automatic logic [15:0] calcExpected();
    longint s = 0;
    for (int k = 0; k < N; k++) s += longint'(x_tb[k]) * longint'(w_tb[k]);
    s = s + (longint'(bias) * 256) + 128;
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef DEC_NEURON_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  task automatic setFrame(input logic [15:0] w, input logic [15:0] x, input logic [15:0] b);
    for (int k = 0; k < N; k++) begin
      w_tb[k] = w;
      x_tb[k] = x;
    end
    bias = b;
  endtask

  task automatic applyStimulus(input int gap);
    exp_q.push_back(calcExpected());
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      checkOutput("beat_ready", 16'(in_ready), 16'd1);
      in_valid = 1'b1;
      in_data  = x_tb[k];
      if (k != N - 1) begin
        repeat (gap) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 16'($urandom);
        end
      end
    end
  endtask

  task automatic waitOutput(input int hold);
    int          lat;
    logic [15:0] exp;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = (hold == 0);
    lat = 1;
    checkOutput("fin_ready", 16'(in_ready), 16'd0);
    checkOutput("fin_valid", 16'(out_valid), 16'd0);
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 16'(lat), 16'd2);
    if (exp_q.size() == 0) begin
      checkOutput("queue_empty", 16'd1, 16'd0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    checkOutput("out_data", out_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 16'(out_valid), 16'd1);
      checkOutput("hold_data", out_data, exp);
      checkOutput("hold_ready", 16'(in_ready), 16'd0);
      if (i == hold - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("ready_after", 16'(in_ready), 16'd1);
    checkOutput("valid_after", 16'(out_valid), 16'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    setFrame(16'h0000, 16'h0000, 16'h0000);
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_data", out_data, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 16'(in_ready), 16'd1);

    setFrame(16'h0100, 16'h0100, 16'h0000);
    applyStimulus(0);
    waitOutput(0);
    checkOutput("unity_const", out_data, 16'h1000);

    setFrame(16'hff00, 16'h0100, 16'h0000);
    applyStimulus(0);
    waitOutput(0);

    setFrame(16'h7fff, 16'h7fff, 16'h0000);
    applyStimulus(0);
    waitOutput(0);

    setFrame(16'h8000, 16'h7fff, 16'h0000);
    applyStimulus(0);
    waitOutput(0);

    setFrame(16'h0000, 16'h0000, 16'h0033);
    applyStimulus(0);
    waitOutput(0);
    applyStimulus(3);
    waitOutput(0);

    // Distinct per-beat weights catch beat-to-weight misalignment.
    for (int k = 0; k < N; k++) begin
      w_tb[k] = 16'(k * 32 - 200);
      x_tb[k] = 16'(300 - k * 45);
    end
    bias = 16'hfe80;
    applyStimulus(3);
    waitOutput(0);

    setFrame(16'h0100, 16'h0100, 16'h0000);
    out_ready = 1'b0;
    applyStimulus(0);
    waitOutput(5);

    // Partial frame then reset: the 7 beats must be discarded.
    setFrame(16'h0100, 16'h0100, 16'h0000);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = x_tb[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midrst_valid", 16'(out_valid), 16'd0);
    checkOutput("midrst_data", out_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready", 16'(in_ready), 16'd1);
    applyStimulus(0);
    waitOutput(0);

    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N; k++) begin
        w_tb[k] = 16'(int'($urandom_range(0, 2047)) - 1024);
        x_tb[k] = 16'(int'($urandom_range(0, 2047)) - 1024);
      end
      bias = 16'(int'($urandom_range(0, 4095)) - 2048);
      applyStimulus(int'($urandom_range(0, 2)));
      waitOutput(int'($urandom_range(0, 3)));
    end

    checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
